fb_port_arbiter: RTL and testbench

Shares the single-port 640x480, 1-bit-per-pixel frame buffer BRAM between three users:
- the VGA scanout reader, which needs fixed latency and has top priority;
- a clear engine that sweeps every address to 0 on command;
- a pixel writer with a req/ack handshake.

The block sits between the display/draw logic and the frame buffer instance. It owns that instance's write-enable, address and data-in pins, and is the only thing that drives them.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/fb_clear_engine.sv | 71 +++++++
 rtl/fb_port_arbiter.sv | 136 +++++++++++++
 tb/tb_fb_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame buffer port arbiter: geometry, FSM states and grant codes.
package fb_pkg;

    localparam int FB_W      = 640;
    localparam int FB_H      = 480;
    localparam int FB_DEPTH  = FB_W * FB_H;
    localparam int FB_ADDR_W = $clog2(FB_DEPTH);

    // Clear engine states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } st_t;

    // Which user owns the frame buffer port in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_CLR  = 2'd2,
        GNT_WR   = 2'd3
    } gnt_t;

endpackage

// File: rtl/fb_clear_engine.sv
// Sweep engine that walks every frame buffer address once, advancing only on cycles
// where the arbiter hands it the port. Raises busy for the whole sweep and pulses done
// one cycle after the final address has been issued.
module fb_clear_engine #(
    parameter int DEPTH  = fb_pkg::FB_DEPTH,
    parameter int ADDR_W = fb_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              grant,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              done
);
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    st_t               state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic              done_reg, done_next;

    // State, sweep counter and done pulse registers; reset aborts any sweep silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // Next state: start only matters when idle, so a restart request mid-sweep is dropped.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_CLEAR;
                    cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (grant) begin
                    if (cnt_reg == LAST_ADDR) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: busy and address come straight from registers, done is already registered.
    always_comb begin
        busy     = (state_reg == ST_CLEAR);
        clr_addr = cnt_reg;
        done     = done_reg;
    end

endmodule

// File: rtl/fb_port_arbiter.sv
// Owns the single frame buffer port and shares it between scanout reads (fixed 3-cycle
// latency, top priority), the clear sweep and the handshaked pixel writer.
module fb_port_arbiter #(
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
    parameter int ADDR_W   = fb_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic              rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_din,
    input  logic              fb_dout
);
    import fb_pkg::*;

    // One bit wider than the address so a depth of exactly 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(FB_DEPTH);

    gnt_t              gnt;
    logic              clr_busy_w;
    logic              clr_done_w;
    logic              clr_grant;
    logic [ADDR_W-1:0] clr_addr;
    logic              rd_in_range;
    logic              wr_in_range;

    logic              fb_we_reg;
    logic [ADDR_W-1:0] fb_addr_reg;
    logic              fb_din_reg;
    logic              wr_ack_reg;
    logic [1:0]        rd_v_reg;
    logic [1:0]        rd_ok_reg;
    logic              rd_valid_reg;
    logic              rd_data_reg;

    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);

    // Port grant: scanout first, then the sweep, then the writer. The writer is held off
    // while a clear is being started and during its own ack cycle, which caps it at one
    // write every two cycles and lets it change address/data while ack is high.
    always_comb begin
        gnt = GNT_NONE;
        if (rd_req) begin
            gnt = GNT_RD;
        end else if (clr_busy_w) begin
            gnt = GNT_CLR;
        end else if (wr_req && !clr_start && !wr_ack_reg) begin
            gnt = GNT_WR;
        end
    end

    assign clr_grant = (gnt == GNT_CLR);

    fb_clear_engine #(
        .DEPTH  (FB_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (clr_start),
        .grant    (clr_grant),
        .busy     (clr_busy_w),
        .clr_addr (clr_addr),
        .done     (clr_done_w)
    );

    // Frame buffer port and write ack. Write enable is a single-cycle strobe; the address
    // follows every grant (reads included) and otherwise holds. Out-of-range writes are
    // acknowledged but never reach the memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we_reg   <= 1'b0;
            fb_addr_reg <= '0;
            fb_din_reg  <= 1'b0;
            wr_ack_reg  <= 1'b0;
        end else begin
            fb_we_reg  <= 1'b0;
            wr_ack_reg <= 1'b0;
            case (gnt)
                GNT_RD: begin
                    fb_addr_reg <= rd_addr;
                end
                GNT_CLR: begin
                    fb_we_reg   <= 1'b1;
                    fb_addr_reg <= clr_addr;
                    fb_din_reg  <= 1'b0;
                end
                GNT_WR: begin
                    fb_we_reg   <= wr_in_range;
                    fb_addr_reg <= wr_addr;
                    fb_din_reg  <= wr_data;
                    wr_ack_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read-valid pipe: stage 0 lines up with the address on the port, stage 1 with the
    // BRAM output, and the final register presents the masked pixel to scanout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v_reg     <= '0;
            rd_ok_reg    <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= 1'b0;
        end else begin
            rd_v_reg     <= {rd_v_reg[0], (gnt == GNT_RD)};
            rd_ok_reg    <= {rd_ok_reg[0], rd_in_range};
            rd_valid_reg <= rd_v_reg[1];
            rd_data_reg  <= rd_v_reg[1] & rd_ok_reg[1] & fb_dout;
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_data_reg;
    assign wr_ack   = wr_ack_reg;
    assign clr_busy = clr_busy_w;
    assign clr_done = clr_done_w;
    assign fb_we    = fb_we_reg;
    assign fb_addr  = fb_addr_reg;
    assign fb_din   = fb_din_reg;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter with a 64-pixel buffer: directed scenarios plus a random
// phase, all checked every cycle against a transaction-level model of the arbiter.
module tb_fb_port_arbiter;

    localparam int DEPTH    = 64;
    localparam int AW       = 19;
    localparam int OOR_ADDR = 307200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_data = 1'b0;
    logic          clr_start = 1'b0;
    logic          rd_valid, rd_data, wr_ack, clr_busy, clr_done, fb_we, fb_din;
    logic [AW-1:0] fb_addr;
    logic          fb_dout = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    fb_port_arbiter #(.FB_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din), .fb_dout(fb_dout)
    );

    // Power-up contents; addresses 10..14 carry the scanout pattern, 5/7/23 start at 0.
    function automatic bit init_val(int a);
        case (a)
            10: return 1'b1;
            11: return 1'b0;
            12: return 1'b1;
            13: return 1'b1;
            14: return 1'b0;
            5, 7, 23: return 1'b0;
            default: return ((a * 13 + 5) % 3) == 0;
        endcase
    endfunction

    // Stand-in for the BRAM: registered read, read-before-write. Out-of-range addresses
    // read as 1 so the arbiter's masking is what makes them 0.
    bit bram [DEPTH];
    initial begin
        bit rv;
        for (int i = 0; i < DEPTH; i++) bram[i] = init_val(i);
        forever begin
            @(posedge clk);
            rv = (int'(fb_addr) < DEPTH) ? bram[int'(fb_addr)] : 1'b1;
            if (fb_we && int'(fb_addr) < DEPTH) bram[int'(fb_addr)] = fb_din;
            fb_dout <= rv;
        end
    end

    // Reference model: decides each cycle who owns the port, keeps its own picture of the
    // memory, and schedules read results three cycles after their grant.
    typedef struct { longint due; bit d; } rd_exp_t;
    rd_exp_t rq[$];
    bit      ref_mem [DEPTH];
    longint  cyc = 0;
    bit      m_clearing = 1'b0;
    int      m_ptr = 0;
    bit      e_we = 1'b0, e_din = 1'b0, e_ack = 1'b0, e_done = 1'b0;
    bit      e_busy = 1'b0, e_rv = 1'b0, e_rd = 1'b0;
    int      e_addr = 0;

    initial begin
        bit was_clr, g_rd, g_clr, g_wr;
        rd_exp_t t;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_clearing = 1'b0; m_ptr = 0;
                e_we = 1'b0; e_din = 1'b0; e_ack = 1'b0; e_done = 1'b0;
                e_busy = 1'b0; e_rv = 1'b0; e_rd = 1'b0; e_addr = 0;
                rq.delete();
            end else begin
                cyc++;
                was_clr = m_clearing;
                g_rd  = rd_req;
                g_clr = was_clr && !rd_req;
                g_wr  = !rd_req && !was_clr && !clr_start && wr_req && !e_ack;
                e_we = 1'b0; e_ack = 1'b0; e_done = 1'b0;
                if (g_rd) begin
                    t.due = cyc + 2;
                    t.d   = 1'b0;
                    if (int'(rd_addr) < DEPTH) t.d = ref_mem[int'(rd_addr)];
                    rq.push_back(t);
                    e_addr = int'(rd_addr);
                end
                if (g_clr) begin
                    e_we = 1'b1; e_din = 1'b0; e_addr = m_ptr;
                    ref_mem[m_ptr] = 1'b0;
                    if (m_ptr == DEPTH - 1) begin
                        m_clearing = 1'b0; m_ptr = 0; e_done = 1'b1;
                    end else begin
                        m_ptr++;
                    end
                end
                if (g_wr) begin
                    e_ack = 1'b1; e_addr = int'(wr_addr);
                    if (int'(wr_addr) < DEPTH) begin
                        e_we = 1'b1; e_din = wr_data;
                        ref_mem[int'(wr_addr)] = wr_data;
                    end
                end
                if (!was_clr && clr_start) begin
                    m_clearing = 1'b1; m_ptr = 0;
                end
                e_busy = m_clearing;
                e_rv = 1'b0;
                if (rq.size() > 0 && rq[0].due == cyc) begin
                    e_rv = 1'b1;
                    e_rd = rq[0].d;
                    void'(rq.pop_front());
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(string name, int act, int lo, int hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic timeout(string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: no response within the cycle budget (t=%0t)", name, $time);
    endtask

    task automatic model_compare();
        chk("rd_valid", int'(rd_valid), int'(e_rv));
        if (e_rv) chk("rd_data", int'(rd_data), int'(e_rd));
        chk("wr_ack", int'(wr_ack), int'(e_ack));
        chk("clr_busy", int'(clr_busy), int'(e_busy));
        chk("clr_done", int'(clr_done), int'(e_done));
        chk("fb_we", int'(fb_we), int'(e_we));
        chk("fb_addr", int'(fb_addr), e_addr);
        if (e_we) chk("fb_din", int'(fb_din), int'(e_din));
    endtask

    // Advance to the next falling edge and check the whole output set against the model.
    task automatic tick();
        @(negedge clk);
        if (cmp_en) model_compare();
    endtask

    // Single isolated read: returns what scanout sees three cycles later.
    task automatic do_read(input int a, output bit v, output bit d);
        rd_req = 1'b1; rd_addr = AW'(a);
        tick();
        rd_req = 1'b0;
        tick();
        tick();
        v = rd_valid; d = rd_data;
    endtask

    initial begin
        int pat [5] = '{1, 0, 1, 1, 0};
        bit got, v, d;
        int busy_cnt, done_cnt, done_at, ack_at;

        // Reset state.
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_wr_ack", int'(wr_ack), 0);
        chk("reset_clr_busy", int'(clr_busy), 0);
        chk("reset_clr_done", int'(clr_done), 0);
        chk("reset_fb_we", int'(fb_we), 0);
        chk("reset_fb_addr", int'(fb_addr), 0);
        cmp_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // Back-to-back scanout reads at 10..14.
        for (int i = 0; i < 10; i++) begin
            if (i >= 3 && i < 8) begin
                chk("lat_valid", int'(rd_valid), 1);
                chk("lat_data", int'(rd_data), pat[i - 3]);
            end
            if (i == 2 || i == 8) chk("lat_valid_edge", int'(rd_valid), 0);
            rd_req = (i < 5);
            rd_addr = AW'(10 + i);
            tick();
        end
        $display("read burst 10..14 issued");

        // Write handshake at address 23 (123 lies beyond the 64-pixel bench buffer).
        wr_req = 1'b1; wr_addr = AW'(23); wr_data = 1'b1;
        got = 1'b0;
        for (int i = 1; i <= 6 && !got; i++) begin
            tick();
            if (wr_ack) begin
                got = 1'b1;
                chk("wr_ack_latency", i, 1);
                chk("wr_fb_we", int'(fb_we), 1);
                chk("wr_fb_addr", int'(fb_addr), 23);
                chk("wr_fb_din", int'(fb_din), 1);
                wr_req = 1'b0;
            end
        end
        if (!got) timeout("wr_ack_wait");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_single_ack", int'(wr_ack), 0);
            chk("wr_single_we", int'(fb_we), 0);
        end
        do_read(23, v, d);
        chk("wr_readback_valid", int'(v), 1);
        chk("wr_readback_data", int'(d), 1);
        $display("write 23 <= 1 acked, read back %0d", d);

        // Reads beat the writer for four cycles, then the write goes through.
        wr_req = 1'b1; wr_addr = AW'(5); wr_data = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_addr = AW'($urandom_range(0, DEPTH - 1));
            tick();
            chk("prio_no_we", int'(fb_we), 0);
            chk("prio_no_ack", int'(wr_ack), 0);
        end
        rd_req = 1'b0;
        tick();
        chk("prio_ack", int'(wr_ack), 1);
        chk("prio_we", int'(fb_we), 1);
        wr_req = 1'b0;
        repeat (4) tick();
        $display("write 5 <= 1 acked after read burst");

        // Clear started together with a write, scanout reading every other cycle.
        clr_start = 1'b1; wr_req = 1'b1; wr_addr = AW'(7); wr_data = 1'b1;
        busy_cnt = 0; done_cnt = 0; done_at = -1; ack_at = -1;
        for (int i = 0; i < 400 && ack_at < 0; i++) begin
            rd_req = (i % 2 == 0);
            rd_addr = AW'($urandom_range(0, DEPTH - 1));
            tick();
            clr_start = 1'b0;
            if (clr_busy) busy_cnt++;
            if (clr_done) begin done_cnt++; done_at = i; end
            if (wr_ack) begin ack_at = i; wr_req = 1'b0; end
        end
        rd_req = 1'b0; wr_req = 1'b0;
        if (ack_at < 0) timeout("clr_pending_write");
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
        end
        chk_range("clr_busy_cycles", busy_cnt, 127, 129);
        chk("clr_done_count", done_cnt, 1);
        chk("clr_write_after_done", int'(ack_at > done_at && done_at >= 0), 1);
        $display("clear swept in %0d busy cycles, pending write acked %0d cycles after done",
                 busy_cnt, ack_at - done_at);

        // Read every address back: all cleared except the write that waited for the sweep.
        for (int i = 0; i < DEPTH + 3; i++) begin
            if (i >= 3) begin
                chk("sweep_valid", int'(rd_valid), 1);
                chk("sweep_data", int'(rd_data), int'((i - 3) == 7));
            end
            rd_req = (i < DEPTH);
            rd_addr = AW'(i);
            tick();
        end
        rd_req = 1'b0;
        repeat (2) tick();
        $display("readback of %0d addresses after clear done", DEPTH);

        // Out-of-range write and read.
        wr_req = 1'b1; wr_addr = AW'(OOR_ADDR); wr_data = 1'b1;
        tick();
        chk("oor_wr_ack", int'(wr_ack), 1);
        chk("oor_fb_we", int'(fb_we), 0);
        wr_req = 1'b0;
        tick();
        do_read(OOR_ADDR, v, d);
        chk("oor_rd_valid", int'(v), 1);
        chk("oor_rd_data", int'(d), 0);
        $display("out-of-range write acked, read returned %0d", d);

        // Reset in the middle of a sweep.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (30) tick();
        chk("pre_reset_busy", int'(clr_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_wr_ack", int'(wr_ack), 0);
        chk("rst_clr_busy", int'(clr_busy), 0);
        chk("rst_clr_done", int'(clr_done), 0);
        chk("rst_fb_we", int'(fb_we), 0);
        chk("rst_fb_addr", int'(fb_addr), 0);
        tick();
        tick();
        chk("rst_hold_busy", int'(clr_busy), 0);
        chk("rst_hold_done", int'(clr_done), 0);
        rst_n = 1'b1; wr_req = 1'b1; wr_addr = AW'(9); wr_data = 1'b1;
        got = 1'b0;
        for (int i = 1; i <= 2 && !got; i++) begin
            tick();
            if (wr_ack) got = 1'b1;
        end
        chk("rst_wr_ack_within_2", int'(got), 1);
        wr_req = 1'b0;
        repeat (3) tick();
        $display("reset mid-sweep, write 9 acked afterwards");

        // Random traffic: writer obeys the hold-until-ack protocol, clears are occasional.
        for (int i = 0; i < 3000; i++) begin
            rd_req = ($urandom_range(0, 9) < 4);
            rd_addr = AW'($urandom_range(0, DEPTH + 8));
            clr_start = ($urandom_range(0, 199) == 0);
            if (wr_ack) wr_req = 1'b0;
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1;
                wr_addr = AW'($urandom_range(0, DEPTH + 8));
                wr_data = 1'($urandom_range(0, 1));
            end
            tick();
        end
        rd_req = 1'b0; wr_req = 1'b0; clr_start = 1'b0;
        repeat (6) tick();
        $display("random phase of 3000 cycles done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "watchdog");
    end

endmodule
